// File: rtl/design67_15_45_top.sv
// design67_15_45_top: two-stage byte pipeline producing a packed result word
//   out = {acc, msb, pop, rx, sum}
// Stage 1 captures the input byte and its predecessor; stage 2 registers the
// sum of the pair plus rotate-xor, popcount, leading-one index and a running
// accumulator of the captured byte.
// Optional feature macro: DESIGN67_ACC_SAT_EN (accumulator saturates at 8'hFF
// instead of wrapping modulo 256).
// Also contains design67_15_45_top_post_route, the same function with the
// input byte and output word flattened to scalar ports.

module design67_15_45_top (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in,
    output logic [31:0] out
);

    logic [7:0] a, b;
    logic [7:0] sum, rx, acc;
    logic [3:0] pop, msb;

    logic [3:0] pop_n, msb_n;
    logic [7:0] acc_n;

    // only the low byte is functional; the rest is dropped here on purpose
    logic unused_in;
    assign unused_in = ^in[31:8];

    // stage 1: current byte and the one before it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a <= '0;
            b <= '0;
        end else begin
            a <= in[7:0];
            b <= a;
        end
    end

    // popcount and highest-set-bit index of a; 4'hF flags a == 0
    always_comb begin
        pop_n = '0;
        msb_n = 4'hF;
        for (int i = 0; i < 8; i++) begin
            if (a[i]) begin
                pop_n = pop_n + 4'd1;
                msb_n = 4'(i);
            end
        end
    end

`ifdef DESIGN67_ACC_SAT_EN
    logic [8:0] acc_sum;
    // saturating accumulate: clamp on carry out of bit 7
    always_comb begin
        acc_sum = {1'b0, acc} + {1'b0, a};
        acc_n   = acc_sum[8] ? 8'hFF : acc_sum[7:0];
    end
`else
    // wrapping accumulate modulo 256
    always_comb begin
        acc_n = acc + a;
    end
`endif

    // stage 2: result fields, all derived from the stage-1 registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum <= '0;
            rx  <= '0;
            pop <= '0;
            msb <= '0;
            acc <= '0;
        end else begin
            sum <= a + b;
            rx  <= a ^ {a[6:0], a[7]};
            pop <= pop_n;
            msb <= msb_n;
            acc <= acc_n;
        end
    end

    // output is pure register fan-out, no path from in
    assign out = {acc, msb, pop, rx, sum};

endmodule

// Scalar-port variant; wraps the core so both views stay functionally identical.
module design67_15_45_top_post_route (
    input  logic clk,
    input  logic rst,
    input  logic in_0, input  logic in_1, input  logic in_2, input  logic in_3,
    input  logic in_4, input  logic in_5, input  logic in_6, input  logic in_7,
    output logic out_0,  output logic out_1,  output logic out_2,  output logic out_3,
    output logic out_4,  output logic out_5,  output logic out_6,  output logic out_7,
    output logic out_8,  output logic out_9,  output logic out_10, output logic out_11,
    output logic out_12, output logic out_13, output logic out_14, output logic out_15,
    output logic out_16, output logic out_17, output logic out_18, output logic out_19,
    output logic out_20, output logic out_21, output logic out_22, output logic out_23,
    output logic out_24, output logic out_25, output logic out_26, output logic out_27,
    output logic out_28, output logic out_29, output logic out_30, output logic out_31
);

    logic [31:0] in_w, out_w;

    assign in_w = {24'h0, in_7, in_6, in_5, in_4, in_3, in_2, in_1, in_0};

    design67_15_45_top u_core (
        .clk (clk),
        .rst (rst),
        .in  (in_w),
        .out (out_w)
    );

    assign {out_31, out_30, out_29, out_28, out_27, out_26, out_25, out_24,
            out_23, out_22, out_21, out_20, out_19, out_18, out_17, out_16,
            out_15, out_14, out_13, out_12, out_11, out_10, out_9,  out_8,
            out_7,  out_6,  out_5,  out_4,  out_3,  out_2,  out_1,  out_0} = out_w;

endmodule

// File: tb/tb_design67_15_45_top.sv
// Bench for design67_15_45_top and its scalar-port variant. Every drive pushes
// the expected post-edge word onto a scoreboard; each test pops and compares.
module tb_design67_15_45_top;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic [31:0] pr_out;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] sb[$];

    // reference state
    int ma = 0, mb = 0, macc = 0;
    logic [31:0] mout = '0;

    always #5 clk = ~clk;

    design67_15_45_top dut (.clk(clk), .rst(rst), .in(din), .out(dout));

    design67_15_45_top_post_route dut_pr (
        .clk(clk), .rst(rst),
        .in_0(din[0]), .in_1(din[1]), .in_2(din[2]), .in_3(din[3]),
        .in_4(din[4]), .in_5(din[5]), .in_6(din[6]), .in_7(din[7]),
        .out_0(pr_out[0]),   .out_1(pr_out[1]),   .out_2(pr_out[2]),   .out_3(pr_out[3]),
        .out_4(pr_out[4]),   .out_5(pr_out[5]),   .out_6(pr_out[6]),   .out_7(pr_out[7]),
        .out_8(pr_out[8]),   .out_9(pr_out[9]),   .out_10(pr_out[10]), .out_11(pr_out[11]),
        .out_12(pr_out[12]), .out_13(pr_out[13]), .out_14(pr_out[14]), .out_15(pr_out[15]),
        .out_16(pr_out[16]), .out_17(pr_out[17]), .out_18(pr_out[18]), .out_19(pr_out[19]),
        .out_20(pr_out[20]), .out_21(pr_out[21]), .out_22(pr_out[22]), .out_23(pr_out[23]),
        .out_24(pr_out[24]), .out_25(pr_out[25]), .out_26(pr_out[26]), .out_27(pr_out[27]),
        .out_28(pr_out[28]), .out_29(pr_out[29]), .out_30(pr_out[30]), .out_31(pr_out[31])
    );

    // advance reference by one clock edge with input byte v
    function automatic void model_edge(input logic [31:0] v);
        logic [7:0] a8, rx8;
        int s, m, p, t;
        if (!rst) begin
            ma = 0; mb = 0; macc = 0; mout = '0;
            return;
        end
        a8  = ma[7:0];
        s   = (ma + mb) % 256;
        rx8 = a8 ^ {a8[6:0], a8[7]};
        p   = $countones(a8);
        m   = (ma == 0) ? 15 : $clog2(ma + 1) - 1;
        t   = macc + ma;
`ifdef DESIGN67_ACC_SAT_EN
        macc = (t > 255) ? 255 : t;
`else
        macc = t % 256;
`endif
        mout = {macc[7:0], m[3:0], p[3:0], rx8, s[7:0]};
        mb = ma;
        ma = int'(v[7:0]);
    endfunction

    // drive one cycle; push either the model word or a fixed expected word
    task automatic drive(input logic [31:0] v, input bit use_const, input logic [31:0] cval);
        din = v;
        model_edge(v);
        sb.push_back(use_const ? cval : mout);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b0;
        model_edge(din);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] e;
        rst = 1'b0;
        din = 32'hFFFF_FFFF;
        #1;
        compared++;
        if (dout !== 32'h0 || pr_out !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_initial: out=%h pr=%h want 00000000", dout, pr_out);
        end
        for (int i = 0; i < 4; i++) begin
            drive(32'hFFFF_FFFF, 1'b1, 32'h0);
            e = sb.pop_front();
            compared++;
            if (dout !== e || pr_out !== e) begin
                mismatched++;
                $display("FAIL reset_hold[%0d]: out=%h pr=%h want %h", i, dout, pr_out, e);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_zero();
        logic [31:0] e;
        for (int i = 0; i < 2; i++) begin
            drive(32'h0, 1'b1, 32'h00F0_0000);
            e = sb.pop_front();
            compared++;
            if (dout !== e || pr_out !== e) begin
                mismatched++;
                $display("FAIL zero_in[%0d]: out=%h pr=%h want %h", i, dout, pr_out, e);
            end
        end
    endtask

    task automatic test_vectors();
        logic [31:0] e;
        logic [31:0] want [4];
        logic [31:0] vin  [4];
        do_reset();
        vin  = '{32'hABCD_EF01, 32'hABCD_EF01, 32'h0000_0080, 32'h0000_0080};
        want = '{32'h00F0_0000, 32'h0101_0301, 32'h0201_0302, 32'h8271_8181};
        for (int i = 0; i < 4; i++) begin
            drive(vin[i], 1'b1, want[i]);
            e = sb.pop_front();
            compared++;
            if (dout !== e || pr_out !== e) begin
                mismatched++;
                $display("FAIL vector[%0d]: out=%h pr=%h want %h", i, dout, pr_out, e);
            end
        end
    endtask

    task automatic test_acc_limit();
        logic [31:0] e;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(32'hFF, 1'b0, 32'h0);
            e = sb.pop_front();
            compared++;
            if (dout !== e || pr_out !== e) begin
                mismatched++;
                $display("FAIL acc_ramp[%0d]: out=%h pr=%h want %h", i, dout, pr_out, e);
            end
        end
`ifdef DESIGN67_ACC_SAT_EN
        drive(32'hFF, 1'b1, 32'hFF78_00FE);
`else
        drive(32'hFF, 1'b1, 32'hF778_00FE);
`endif
        e = sb.pop_front();
        compared++;
        if (dout !== e || pr_out !== e) begin
            mismatched++;
            $display("FAIL acc_limit: out=%h pr=%h want %h", dout, pr_out, e);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] e;
        for (int i = 0; i < 6; i++) begin
            drive(32'h0000_00F3, 1'b0, 32'h0);
            e = sb.pop_front();
            compared++;
            if (dout !== e || pr_out !== e) begin
                mismatched++;
                $display("FAIL pre_reset[%0d]: out=%h pr=%h want %h", i, dout, pr_out, e);
            end
        end
        #2;
        rst = 1'b0;
        model_edge(din);
        #1;
        compared++;
        if (dout !== 32'h0 || pr_out !== 32'h0) begin
            mismatched++;
            $display("FAIL mid_reset_async: out=%h pr=%h want 00000000", dout, pr_out);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        for (int i = 0; i < 60; i++) begin
            drive($urandom, 1'b0, 32'h0);
            e = sb.pop_front();
            compared++;
            if (dout !== e || pr_out !== e) begin
                mismatched++;
                $display("FAIL b2b[%0d]: out=%h pr=%h want %h", i, dout, pr_out, e);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] e, v;
        for (int i = 0; i < 1000; i++) begin
            v = $urandom;
            if (i % 50 == 0) v = {$urandom, 8'h00} & 32'hFFFF_FF00;
            for (int k = 0; k < 2; k++) begin
                drive(v, 1'b0, 32'h0);
                e = sb.pop_front();
                compared++;
                if (dout !== e || pr_out !== e) begin
                    mismatched++;
                    $display("FAIL random[%0d.%0d]: in=%h out=%h pr=%h want %h", i, k, v, dout, pr_out, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_vectors();
        test_acc_limit();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
